uart_seg_display: RTL and testbench
===================================

# uart_seg_display

UART-driven multi-digit 7-segment display controller with multiplexed digit scanning. A serial byte stream (ASCII or raw digit codes) is shifted into an N-digit display buffer and time-multiplexed onto shared segment lines. It sits between the Bluetooth/UART module pin and the board's segment and digit-select pins. It generalises the single-digit receiver to a parametrised baud divisor, parametrised digit count, framing-error detection, a clear command and an optional echo transmitter.

## Interface
- `CLKS_PER_BIT`, 234: clock cycles per UART bit (27 MHz / 115200). Must be ≥ 4.
- `NUM_DIGITS`, 4: number of display digits. Range 1–8.
- `SCAN_DIV`, 27000: clock cycles each digit is driven per scan step.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `uart_rx` in 1: serial input, 8N1, idle high, asynchronous to `clk`.
- `uart_tx` out 1: echo serial output, 8N1, idle high.
- `seg` out 7: segment drive, active-high, registered.
- `dig` out NUM_DIGITS: one-hot digit select, active-high, registered.
- `byte_valid` out 1: one-cycle pulse when a byte is received with a good stop bit.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.

## Operation
- `uart_rx` passes through a 2-flop synchroniser; all RX logic uses the synchronised value.
- RX FSM states:
  - IDLE: a low input moves to START with the counter cleared.
  - START: at `CLKS_PER_BIT/2`, a still-low input moves to DATA. A high input is a false start and returns to IDLE with no pulse.
  - DATA: samples 8 bits, LSB first, each `CLKS_PER_BIT` apart at bit centre.
  - STOP: samples one bit centre later. High pulses `byte_valid`; low pulses `frame_err` and discards the byte. Either way the FSM returns to IDLE immediately, so a back-to-back start bit is accepted.
- Byte decode, applied only on `byte_valid`:
  - 0x30–0x39 or 0x00–0x09: buffer shifts one digit toward the MSD. The new value (low nibble) enters digit 0, the rightmost. The MSD is discarded.
  - 0x0D: all digits are set to blank.
  - Any other byte: no buffer change.
- Each buffer entry is 4 bits; 4'hF means blank.
- Segment codes:
  - 0=7'h3F, 1=7'h09, 2=7'h5E, 3=7'h5B, 4=7'h69
  - 5=7'h73, 6=7'h77, 7=7'h19, 8=7'h7F, 9=7'h7B
  - blank=7'h00
- Scan:
  - The scan counter runs 0..`SCAN_DIV`-1.
  - On wrap, the digit index advances 0..`NUM_DIGITS`-1 and then wraps to 0.
  - Every cycle, `dig` is registered as one-hot(index) and `seg` as encode(buffer[index]).

## Timing
- Reset values: `seg`=0, `dig`=0, `byte_valid`=0, `frame_err`=0, `uart_tx`=1. Buffer is all blank, scan index is 0, and both FSMs are in IDLE.
- First clock after reset release: `dig`=1, `seg`=0.
- `reset` asserted mid-frame aborts RX/TX at once. `uart_tx` returns to 1 asynchronously and the partial byte is discarded.
- `byte_valid` rises 2 (sync) + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` cycles (±1) after the falling start edge on `uart_rx`.
- The buffer update is on the same edge as `byte_valid`. The new digit appears on `seg` at most 1 cycle after its index is next selected.
- A buffer update and a scan advance in the same cycle are both applied. `seg` reflects the post-update buffer one cycle later.
- `byte_valid` and `frame_err` are never high together.

## Configuration
- `UART_SEG_ECHO_EN` defined:
  - The TX FSM (IDLE, START, DATA, STOP, each `CLKS_PER_BIT` long) echoes every `byte_valid` byte, including ignored codes.
  - Transmission starts the cycle after `byte_valid`.
  - A one-entry holding register holds a byte that arrives while TX is busy. If the holding register is already full, it is overwritten with the newest byte.
- Not defined: no TX logic is built; `uart_tx` is tied to 1.

## Test plan
- Send ASCII "1","2","3","4" at 115200 (`NUM_DIGITS`=4). Expect 4 `byte_valid` pulses. Scanning shows `seg` 7'h5B? no: digit3=7'h09, digit2=7'h5E, digit1=7'h5B, digit0=7'h69.
- Send 0x07, then 0x0D. Expect digit0=7'h19, then all digits `seg`=7'h00 on every `dig` step.
- Send 0x35 with the stop bit forced low. Expect a `frame_err` pulse, no `byte_valid` pulse, and an unchanged buffer. A following good 0x36 is received correctly.
- Apply a 0.3-bit low glitch on `uart_rx`. Expect no pulse and the FSM back in IDLE. Assert `reset` mid-byte: expect reset values and a blank display.
- With echo enabled, send 3 back-to-back bytes 0x31, 0x41, 0x32. Expect 0x31 and 0x41 echoed on `uart_tx`. Expect 0x32 echoed if the holding register was freed in time, otherwise 0x41 replaced by 0x32, per the holding rule. Expect `uart_tx`=1 throughout when the macro is undefined.
- With `SCAN_DIV`=4 and `NUM_DIGITS`=3, expect `dig` to cycle 001→010→100→001, each held for exactly 4 cycles.

Source files
------------

// File: rtl/uart_seg_display.sv
// UART-driven multi-digit 7-segment display controller.
// Received bytes shift decimal digits into an N-digit buffer that is scanned
// onto shared segment lines. Optional echo transmitter: define UART_SEG_ECHO_EN.
`timescale 1ns/1ps
module uart_seg_display #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 27000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_uart_rx,
  output logic                  o_uart_tx,
  output logic [6:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_dig,
  output logic                  o_byte_valid,
  output logic                  o_frame_err
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] FullCnt = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfCnt = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_t;

  logic            r_rx_meta, r_rx_sync;
  rx_state_t       r_rx_state;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_rx_shift;
  logic            r_byte_valid, r_frame_err;
  logic [3:0]      r_buf [NUM_DIGITS];
  logic [SW-1:0]   r_scan_cnt;
  logic [IW-1:0]   r_scan_idx;
  logic [NUM_DIGITS-1:0] r_dig, w_dig;
  logic [6:0]      r_seg;
  logic            w_rx_done, w_is_digit;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'h3F;
      4'd1:    seg_encode = 7'h09;
      4'd2:    seg_encode = 7'h5E;
      4'd3:    seg_encode = 7'h5B;
      4'd4:    seg_encode = 7'h69;
      4'd5:    seg_encode = 7'h73;
      4'd6:    seg_encode = 7'h77;
      4'd7:    seg_encode = 7'h19;
      4'd8:    seg_encode = 7'h7F;
      4'd9:    seg_encode = 7'h7B;
      default: seg_encode = 7'h00;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX FSM: start-bit qualification, 8 data bits LSB first, stop-bit check.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_state   <= StIdle;
      r_rx_cnt     <= '0;
      r_bit_idx    <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        StIdle: begin
          r_rx_cnt  <= '0;
          r_bit_idx <= '0;
          if (!r_rx_sync) r_rx_state <= StStart;
        end
        StStart: begin
          if (r_rx_cnt == HalfCnt) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_sync ? StIdle : StData;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_rx_cnt == FullCnt) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= StStop;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_rx_cnt == FullCnt) begin
            r_rx_cnt   <= '0;
            r_rx_state <= StIdle;
            if (r_rx_sync) r_byte_valid <= 1'b1;
            else           r_frame_err  <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= StIdle;
      endcase
    end
  end

  // Good-stop sample strobe; r_rx_shift holds the complete byte here.
  assign w_rx_done  = (r_rx_state == StStop) && (r_rx_cnt == FullCnt) && r_rx_sync;
  assign w_is_digit = ((r_rx_shift >= 8'h30) && (r_rx_shift <= 8'h39)) || (r_rx_shift <= 8'h09);

  // Display buffer: digits shift in at position 0, CR blanks everything.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= 4'hF;
    end else if (w_rx_done) begin
      if (w_is_digit) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
        r_buf[0] <= r_rx_shift[3:0];
      end else if (r_rx_shift == 8'h0D) begin
        for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= 4'hF;
      end
    end
  end

  // One-hot decode of the current scan index.
  always_comb begin
    w_dig             = '0;
    w_dig[r_scan_idx] = 1'b1;
  end

  // Scan timer and registered segment/digit drive.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_dig      <= '0;
      r_seg      <= '0;
    end else begin
      if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_scan_idx <= (r_scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_dig <= w_dig;
      r_seg <= seg_encode(r_buf[r_scan_idx]);
    end
  end

`ifdef UART_SEG_ECHO_EN
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_data, r_hold;
  logic          r_hold_vld, r_tx;

  // Echo TX FSM; a byte arriving while busy parks in r_hold (newest wins).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      if (r_byte_valid && (r_tx_state != TxIdle)) begin
        r_hold     <= r_rx_shift;
        r_hold_vld <= 1'b1;
      end
      case (r_tx_state)
        TxIdle: begin
          r_tx_cnt <= '0;
          r_tx_idx <= '0;
          if (r_hold_vld) begin
            r_tx_data  <= r_hold;
            r_tx       <= 1'b0;
            r_tx_state <= TxStart;
            r_hold_vld <= r_byte_valid;
            if (r_byte_valid) r_hold <= r_rx_shift;
          end else if (r_byte_valid) begin
            r_tx_data  <= r_rx_shift;
            r_tx       <= 1'b0;
            r_tx_state <= TxStart;
          end
        end
        TxStart: begin
          if (r_tx_cnt == FullCnt) begin
            r_tx_cnt   <= '0;
            r_tx       <= r_tx_data[0];
            r_tx_data  <= {1'b0, r_tx_data[7:1]};
            r_tx_state <= TxData;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TxData: begin
          if (r_tx_cnt == FullCnt) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= TxStop;
            end else begin
              r_tx      <= r_tx_data[0];
              r_tx_data <= {1'b0, r_tx_data[7:1]};
              r_tx_idx  <= r_tx_idx + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TxStop: begin
          if (r_tx_cnt == FullCnt) begin
            r_tx_cnt   <= '0;
            r_tx_state <= TxIdle;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= TxIdle;
      endcase
    end
  end

  assign o_uart_tx = r_tx;
`else
  assign o_uart_tx = 1'b1;
`endif

  assign o_seg        = r_seg;
  assign o_dig        = r_dig;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
endmodule

// File: tb/tb_uart_seg_display.sv
// Scoreboard bench for uart_seg_display with short bit and scan periods.
`timescale 1ns/1ps
module tb_uart_seg_display;
  localparam int unsigned CPB  = 16;
  localparam int unsigned ND   = 4;
  localparam int unsigned SDIV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          tx, bv, fe;
  logic [6:0]    seg;
  logic [ND-1:0] dig;

  int n_vec = 0;
  int n_err = 0;
  int exp_ev[$];            // 1 = byte_valid expected, 2 = frame_err expected
  logic [7:0] exp_echo[$];
  logic [7:0] got_echo[$];
  logic [3:0] m_buf[ND];
  int tx_low = 0;

  uart_seg_display #(
    .CLKS_PER_BIT(CPB),
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SDIV)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_uart_rx   (rx),
    .o_uart_tx   (tx),
    .o_seg       (seg),
    .o_dig       (dig),
    .o_byte_valid(bv),
    .o_frame_err (fe)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: exp_seg = 7'h3F;  4'd1: exp_seg = 7'h09;  4'd2: exp_seg = 7'h5E;
      4'd3: exp_seg = 7'h5B;  4'd4: exp_seg = 7'h69;  4'd5: exp_seg = 7'h73;
      4'd6: exp_seg = 7'h77;  4'd7: exp_seg = 7'h19;  4'd8: exp_seg = 7'h7F;
      4'd9: exp_seg = 7'h7B;  default: exp_seg = 7'h00;
    endcase
  endfunction

  // Pulse monitor: pops the scoreboard on every byte_valid / frame_err.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx === 1'b0) tx_low++;
      if (bv === 1'b1 || fe === 1'b1) begin
        int k;
        n_vec++;
        if (bv === 1'b1 && fe === 1'b1) begin
          n_err++;
          $display("FAIL pulse_overlap: byte_valid=%b frame_err=%b, required not both", bv, fe);
        end else if (exp_ev.size() == 0) begin
          n_err++;
          $display("FAIL pulse_unexpected: byte_valid=%b frame_err=%b, required no pulse", bv, fe);
        end else begin
          k = exp_ev.pop_front();
          if ((k == 1) !== (bv === 1'b1)) begin
            n_err++;
            $display("FAIL pulse_kind: byte_valid=%b frame_err=%b, required kind %0d", bv, fe, k);
          end
        end
      end
    end
  end

`ifdef UART_SEG_ECHO_EN
  // Echo decoder: samples uart_tx near each bit centre.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        got_echo.push_back(b);
      end
    end
  end
`endif

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bench model of the buffer and expected pulses for a good byte.
  task automatic model_byte(input logic [7:0] b);
    if ((b >= 8'h30 && b <= 8'h39) || b <= 8'h09) begin
      for (int i = ND - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
      m_buf[0] = b[3:0];
    end else if (b == 8'h0D) begin
      for (int i = 0; i < ND; i++) m_buf[i] = 4'hF;
    end
    exp_ev.push_back(1);
    exp_echo.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) model_byte(b);
    else exp_ev.push_back(2);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_bit;
    wait_cyc(CPB);
    rx = 1'b1;
  endtask

  task automatic check_display(input string name);
    for (int i = 0; i < ND; i++) begin
      logic [ND-1:0] ed;
      int t;
      ed = '0;
      ed[i] = 1'b1;
      t = 0;
      @(negedge clk);
      while (dig !== ed && t < 4 * ND * SDIV + 8) begin
        @(negedge clk);
        t++;
      end
      n_vec++;
      if (dig !== ed) begin
        n_err++;
        $display("FAIL %s_scan_timeout: dig=%b, required %b", name, dig, ed);
      end else if (seg !== exp_seg(m_buf[i])) begin
        n_err++;
        $display("FAIL %s_digit%0d: seg=%h, required %h", name, i, seg, exp_seg(m_buf[i]));
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec += 5;
    if (seg !== 7'h00) begin n_err++; $display("FAIL %s_seg: %h, required 00", name, seg); end
    if (dig !== '0) begin n_err++; $display("FAIL %s_dig: %b, required 0", name, dig); end
    if (bv !== 1'b0) begin n_err++; $display("FAIL %s_bv: %b, required 0", name, bv); end
    if (fe !== 1'b0) begin n_err++; $display("FAIL %s_fe: %b, required 0", name, fe); end
    if (tx !== 1'b1) begin n_err++; $display("FAIL %s_tx: %b, required 1", name, tx); end
  endtask

  task automatic check_first_clock(input string name);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (dig !== ND'(1) || seg !== 7'h00) begin
      n_err++;
      $display("FAIL %s_first_clk: dig=%b seg=%h, required dig=1 seg=00", name, dig, seg);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < ND; i++) m_buf[i] = 4'hF;
    wait_cyc(3);
    check_reset_outputs("reset");
    check_first_clock("reset");
  endtask

  // Each digit must be held for exactly SDIV cycles, wrapping after ND.
  task automatic test_scan();
    int t;
    t = 0;
    @(negedge clk);
    while (dig !== ND'(2) && t < 40) begin
      @(negedge clk);
      t++;
    end
    for (int j = 0; j < 4 * ND; j++) begin
      logic [ND-1:0] ed;
      if (j > 0) @(negedge clk);
      ed = '0;
      ed[(1 + j / SDIV) % ND] = 1'b1;
      n_vec++;
      if (dig !== ed) begin
        n_err++;
        $display("FAIL scan_step%0d: dig=%b, required %b", j, dig, ed);
      end
    end
  endtask

  task automatic test_digits();
    send_frame(8'h31, 1'b1);
    send_frame(8'h32, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_cyc(4);
    check_display("ascii_1234");
  endtask

  task automatic test_raw_and_clear();
    send_frame(8'h07, 1'b1);
    wait_cyc(4);
    check_display("raw_07");
    send_frame(8'h0D, 1'b1);
    wait_cyc(4);
    check_display("clear");
  endtask

  task automatic test_frame_err();
    send_frame(8'h35, 1'b0);
    wait_cyc(2 * CPB);
    check_display("frame_err_hold");
    send_frame(8'h36, 1'b1);
    wait_cyc(4);
    check_display("after_frame_err");
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(3 * CPB);
    n_vec++;
    if (exp_ev.size() != 0) begin
      n_err++;
      $display("FAIL glitch_pending: %0d pulses outstanding, required 0", exp_ev.size());
    end
    check_display("glitch_hold");
    send_frame(8'h39, 1'b1);
    wait_cyc(4);
    check_display("after_glitch");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h31, 1'b1);
    send_frame(8'h41, 1'b1);
    send_frame(8'h32, 1'b1);
    wait_cyc(4);
    check_display("back_to_back");
    wait_cyc(40 * CPB);
  endtask

  task automatic test_reset_mid();
    rx = 1'b0;
    wait_cyc(3 * CPB);
    #2;
    reset = 1'b1;
    #1;
    rx = 1'b1;
    for (int i = 0; i < ND; i++) m_buf[i] = 4'hF;
    check_reset_outputs("reset_mid");
    wait_cyc(3);
    check_first_clock("reset_mid");
    check_display("reset_mid_blank");
    send_frame(8'h38, 1'b1);
    wait_cyc(4);
    check_display("after_reset_mid");
    wait_cyc(12 * CPB);
  endtask

  task automatic test_end();
    n_vec++;
    if (exp_ev.size() != 0) begin
      n_err++;
      $display("FAIL pulses_missing: %0d outstanding, required 0", exp_ev.size());
    end
`ifdef UART_SEG_ECHO_EN
    n_vec++;
    if (got_echo.size() != exp_echo.size()) begin
      n_err++;
      $display("FAIL echo_count: %0d, required %0d", got_echo.size(), exp_echo.size());
    end else begin
      for (int i = 0; i < exp_echo.size(); i++) begin
        n_vec++;
        if (got_echo[i] !== exp_echo[i]) begin
          n_err++;
          $display("FAIL echo_byte%0d: %h, required %h", i, got_echo[i], exp_echo[i]);
        end
      end
    end
`else
    n_vec++;
    if (tx_low != 0) begin
      n_err++;
      $display("FAIL tx_idle: uart_tx low for %0d cycles, required 0", tx_low);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_scan();
    test_digits();
    test_raw_and_clear();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_end();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
